hazard_scoreboard: RTL and testbench

- Generates `hazard_detected` for the ID-stage controller.
- Tracks every in-flight register write between EXE and WB in a per-register countdown scoreboard.
- Stalls ID while an instruction reads a source register whose producer has not yet reached a readable point.
- Sits beside the ID stage: its inputs are the controller's `WB_EN`/`MEM_R_EN` and the decoded register fields; its output feeds the controller's `hazard_detected` and the IF/ID hold logic.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Purpose: ID-stage hazard detector. Every register write that issues from ID
// loads a per-register countdown with PIPE_DEPTH. The countdown drains by one
// each clock as the producer moves through EXE, MEM and WB. An ID instruction
// that reads a register whose countdown is still running is held. The stall
// request is combinational and goes to the controller and the IF/ID hold logic.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   - a forwarding unit exists, so only a load-use dependency in the
//               first cycle after the load issues (count == PIPE_DEPTH) stalls.
//   undefined - any running countdown on a source register stalls.
//
// Ports:
//   clk             in  rising-edge clock
//   rst             in  asynchronous active-high reset
//   id_valid        in  a real instruction occupies ID
//   flush           in  ID instruction is squashed this cycle
//   src1, src2      in  source register addresses
//   src2_used       in  src2 is really read by this instruction
//   dest            in  destination register address
//   wb_en           in  instruction writes dest
//   mem_r_en        in  instruction is a load
//   hazard_detected out combinational stall request
//   busy            out registered: any scoreboard entry nonzero
//   stall_count     out registered saturating count of stall cycles

module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src2_used,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  input  logic                  mem_r_en,
  output logic                  hazard_detected,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int ENT_W    = $clog2(PIPE_DEPTH + 1);
  localparam logic [ENT_W-1:0] DEPTH_VAL = ENT_W'(PIPE_DEPTH);

  logic [ENT_W-1:0]    cnt     [NUM_REGS];
  logic [ENT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] ld;
  logic [NUM_REGS-1:0] ld_nxt;
  logic                match1;
  logic                match2;
  logic                issue;
  logic                busy_nxt;

  // Source match against the current (pre-update) scoreboard, so an
  // instruction that writes one of its own sources never stalls on itself.
  // Register 0 is hardwired and never produces a dependency.
  always_comb begin
`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers everything except a load whose data is not out of
    // MEM yet, which is only the first cycle after the load issues.
    match1 = (src1 != '0) && ld[src1] && (cnt[src1] == DEPTH_VAL);
    match2 = src2_used && (src2 != '0) && ld[src2] && (cnt[src2] == DEPTH_VAL);
`else
    // Without forwarding, a source is only safe once its writer has left WB;
    // the register file is not write-through, so count 1 still stalls.
    match1 = (src1 != '0) && (cnt[src1] != '0);
    match2 = src2_used && (src2 != '0) && (cnt[src2] != '0);
`endif
  end

  // A flushed instruction neither stalls nor issues.
  assign hazard_detected = id_valid && !flush && (match1 || match2);
  assign issue           = id_valid && !flush && !hazard_detected;

  // Next scoreboard state: a fresh issue reloads its destination, overriding
  // the drain and any older pending writer to the same register.
  always_comb begin
    busy_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      ld_nxt[r]  = ld[r];
      if (r == 0) begin
        cnt_nxt[r] = '0;
        ld_nxt[r]  = 1'b0;
      end else if (issue && wb_en && (dest == REG_ADDR_W'(r))) begin
        cnt_nxt[r] = DEPTH_VAL;
        ld_nxt[r]  = mem_r_en;
      end else if (cnt[r] != '0) begin
        cnt_nxt[r] = cnt[r] - ENT_W'(1);
      end
      busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
    end
  end

  // State registers; reset empties the scoreboard, which also forces
  // hazard_detected low without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      ld          <= '0;
      busy        <= 1'b0;
      stall_count <= '0;
    end else begin
      cnt  <= cnt_nxt;
      ld   <= ld_nxt;
      busy <= busy_nxt;
      if (hazard_detected && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Purpose: self-checking bench for hazard_scoreboard. The reference model keeps,
// per register, the clock-edge number at which its latest writer issued; a
// register is unreadable while fewer than PIPE_DEPTH edges have passed since.
// Expected outputs are queued per cycle and checked by an independent monitor.
// The stall counter is narrowed to 4 bits so saturation is reached in the
// randomized phase.
//
// Ports: none (top-level bench).

module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int PIPE_DEPTH = 3;
  localparam int CNT_W      = 4;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int SC_MAX     = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic                  flush;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  src2_used;
  logic [REG_ADDR_W-1:0] dest;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  hazard_detected;
  logic                  busy;
  logic [CNT_W-1:0]      stall_count;

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W),
    .PIPE_DEPTH(PIPE_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .flush(flush),
    .src1(src1),
    .src2(src2),
    .src2_used(src2_used),
    .dest(dest),
    .wb_en(wb_en),
    .mem_r_en(mem_r_en),
    .hazard_detected(hazard_detected),
    .busy(busy),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    haz;
    bit    busy;
    int    sc;
    string tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: edge number of the latest issuing writer per register.
  int now;
  int issue_edge [NUM_REGS];
  bit ld_m       [NUM_REGS];
  int sc_m;

  function automatic bit pending(int r);
    return (r != 0) && (now < issue_edge[r] + PIPE_DEPTH);
  endfunction

  function automatic bit src_blocks(int r);
`ifdef HAZARD_FORWARDING_EN
    return (r != 0) && ld_m[r] && (now == issue_edge[r]);
`else
    return pending(r);
`endif
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pending(r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      issue_edge[r] = -1000;
      ld_m[r]       = 1'b0;
    end
    sc_m = 0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal({e.tag, ".hazard"}, 32'(hazard_detected), 32'(e.haz));
    checkVal({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    checkVal({e.tag, ".stall_count"}, 32'(stall_count), 32'(e.sc));
  endtask

  // Drives one ID cycle (entered just after a rising edge), queues the
  // expected response, then advances the model across the next edge.
  task automatic applyStimulus(input bit v, input bit fl, input int s1, input int s2,
                               input bit s2u, input int d, input bit wb, input bit mr,
                               input string tag, output bit haz);
    exp_t e;
    id_valid  = v;
    flush     = fl;
    src1      = s1[REG_ADDR_W-1:0];
    src2      = s2[REG_ADDR_W-1:0];
    src2_used = s2u;
    dest      = d[REG_ADDR_W-1:0];
    wb_en     = wb;
    mem_r_en  = mr;
    haz    = v && !fl && (src_blocks(s1) || (s2u && src_blocks(s2)));
    e.haz  = haz;
    e.busy = any_pending();
    e.sc   = sc_m;
    e.tag  = tag;
    q.push_back(e);
    @(posedge clk);
    now++;
    if (v && !fl && !haz && wb && (d != 0)) begin
      issue_edge[d] = now;
      ld_m[d]       = mr;
    end
    if (haz && (sc_m != SC_MAX)) sc_m++;
    #1;
  endtask

  // Re-presents a held instruction until it issues; returns stall cycles.
  task automatic hold_until_issue(input int s1, input int s2, input bit s2u, input int d,
                                  input bit wb, input bit mr, input string tag,
                                  output int stalls);
    bit haz;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, s1, s2, s2u, d, wb, mr, tag, haz);
      if (!haz) return;
      stalls++;
    end
    checkVal({tag, ".hold_timeout"}, 32'(1), 32'(0));
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    bit haz;
    int stalls;
    int sc_before;

    rst = 1'b1;
    id_valid = 1'b0; flush = 1'b0; src1 = '0; src2 = '0; src2_used = 1'b0;
    dest = '0; wb_en = 1'b0; mem_r_en = 1'b0;
    now = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Empty scoreboard after reset.
    applyStimulus(1, 0, 1, 2, 1, 0, 0, 0, "reset_empty", haz);

    // ALU producer followed by a dependent reader.
    sc_before = int'(stall_count);
    applyStimulus(1, 0, 1, 2, 1, 3, 1, 0, "alu_prod", haz);
    hold_until_issue(3, 4, 1, 8, 1, 0, "alu_use", stalls);
`ifdef HAZARD_FORWARDING_EN
    checkVal("alu_use.stall_cycles", 32'(stalls), 32'(0));
`else
    checkVal("alu_use.stall_cycles", 32'(stalls), 32'(3));
    checkVal("alu_use.stall_count_delta", 32'(int'(stall_count) - sc_before), 32'(3));
`endif

    // Load producer followed by a dependent reader.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle", haz);
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 1, "ld_prod", haz);
    hold_until_issue(5, 0, 0, 6, 1, 0, "ld_use", stalls);
`ifdef HAZARD_FORWARDING_EN
    checkVal("ld_use.stall_cycles", 32'(stalls), 32'(1));
`else
    checkVal("ld_use.stall_cycles", 32'(stalls), 32'(3));
`endif
    hold_until_issue(6, 0, 0, 0, 0, 0, "alu_after_ld", stalls);

    // Writes to r0 are ignored; an unused src2 never matches.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle", haz);
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, "r0_write", haz);
    applyStimulus(1, 0, 0, 0, 1, 2, 0, 0, "r0_read", haz);
    applyStimulus(1, 0, 1, 0, 0, 7, 1, 0, "r7_prod", haz);
    applyStimulus(1, 0, 1, 7, 0, 0, 0, 0, "r7_src2_unused", haz);

    // Flush beats a hazard and leaves no entry behind.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle", haz);
    applyStimulus(1, 0, 1, 0, 0, 4, 1, 0, "r4_prod", haz);
    applyStimulus(1, 1, 4, 0, 0, 10, 1, 0, "r4_flushed", haz);
    applyStimulus(1, 0, 10, 10, 1, 0, 0, 0, "r10_no_entry", haz);

    // Youngest writer reloads the entry.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle", haz);
    applyStimulus(1, 0, 1, 0, 0, 9, 1, 0, "r9_first", haz);
    applyStimulus(1, 0, 2, 0, 0, 9, 1, 0, "r9_second", haz);
    hold_until_issue(9, 0, 0, 0, 0, 0, "r9_use", stalls);
`ifndef HAZARD_FORWARDING_EN
    checkVal("r9_use.stall_cycles", 32'(stalls), 32'(3));
`endif

    // Asynchronous reset while a reader is stalled.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle", haz);
    applyStimulus(1, 0, 1, 0, 0, 12, 1, 1, "r12_prod", haz);
    id_valid = 1'b1; flush = 1'b0; src1 = 5'd12; src2 = '0; src2_used = 1'b0;
    dest = '0; wb_en = 1'b0; mem_r_en = 1'b0;
    #1 checkVal("pre_reset.hazard", 32'(hazard_detected), 32'(1));
    rst = 1'b1;
    #1;
    checkVal("async_reset.hazard", 32'(hazard_detected), 32'(0));
    checkVal("async_reset.busy", 32'(busy), 32'(0));
    checkVal("async_reset.stall_count", 32'(stall_count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    id_valid = 1'b0;
    model_reset();

    // Randomized instruction stream over a small register window.
    for (int i = 0; i < 400; i++) begin
      bit rv, rfl, rs2u, rwb, rmr;
      rv   = ($urandom_range(0, 9) != 0);
      rfl  = ($urandom_range(0, 9) == 0);
      rs2u = 1'($urandom_range(0, 1));
      rwb  = ($urandom_range(0, 3) != 0);
      rmr  = rwb && ($urandom_range(0, 2) == 0);
      applyStimulus(rv, rfl, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rs2u,
                    int'($urandom_range(0, 7)), rwb, rmr, "random", haz);
    end

    id_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) checkVal("queue_drain", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
